data_mem_ctrl: RTL



---
 rtl/data_mem_ctrl_if.sv | 26 ++
 rtl/data_mem_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus of the byte-addressable data memory controller.
// The master drives requests; the slave (data_mem_ctrl) returns ready and a pulsed response.
interface data_mem_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Little-endian byte/half/word data memory with programmable wait states and a pulsed response.
// Define MISALIGN_TRAP_EN to reject misaligned halfword/word accesses with resp_err.
module data_mem_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    data_mem_ctrl_if.slave bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = 4;
    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_WORD = 2'b10;
    localparam logic [1:0]  SZ_RSVD = 2'b11;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;

    logic                   ready_q;
    logic                   resp_valid_q;
    logic [31:0]            resp_rdata_q;
    logic                   resp_err_q;

    logic                   lat_we;
    logic                   lat_uns;
    logic [1:0]             lat_size;
    logic [DEPTH_LOG2-1:0]  lat_addr;
    logic [31:0]            lat_wdata;

    logic                   accept_c;
    logic                   complete_c;
    logic                   misalign_c;
    logic                   err_c;
    logic                   ready_d;
    logic [31:0]            rdata_c;

    logic [DEPTH_LOG2-1:0]  a [4];
    logic [7:0]             b [4];
    logic [7:0]             mem [DEPTH];

    logic                   addr_unused;

    assign addr_unused = ^bus.req_addr[ADDR_WIDTH-1:DEPTH_LOG2];

    // ready_q is only ever high while IDLE, so it doubles as the accept qualifier
    assign accept_c = ready_q & bus.req_valid;

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(WAIT_STATES);
                end
            end
            BUSY: begin
                if (cnt == '0) state_d = IDLE;
                else           cnt_d   = cnt - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Byte lanes of the latched access, wrapping modulo the array size
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            a[k] = lat_addr + DEPTH_LOG2'(k);
            b[k] = mem[a[k]];
        end
    end

    // Output logic: completion, error and extended load data
    always_comb begin
        ready_d    = (state_d == IDLE);
        complete_c = (state == BUSY) && (cnt == '0);
`ifdef MISALIGN_TRAP_EN
        misalign_c = ((lat_size == SZ_HALF) && lat_addr[0]) ||
                     ((lat_size == SZ_WORD) && (lat_addr[1:0] != 2'b00));
`else
        misalign_c = 1'b0;
`endif
        err_c   = (lat_size == SZ_RSVD) | misalign_c;
        rdata_c = '0;
        if (!err_c && !lat_we) begin
            case (lat_size)
                SZ_BYTE: rdata_c = lat_uns ? {24'h0, b[0]} : {{24{b[0][7]}}, b[0]};
                SZ_HALF: rdata_c = lat_uns ? {16'h0, b[1], b[0]}
                                           : {{16{b[1][7]}}, b[1], b[0]};
                SZ_WORD: rdata_c = {b[3], b[2], b[1], b[0]};
                default: rdata_c = '0;
            endcase
        end
    end

    // Registered outputs and request latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            lat_we       <= 1'b0;
            lat_uns      <= 1'b0;
            lat_size     <= '0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
        end else begin
            ready_q      <= ready_d;
            resp_valid_q <= complete_c;
            if (complete_c) begin
                resp_rdata_q <= rdata_c;
                resp_err_q   <= err_c;
            end
            if (accept_c) begin
                lat_we    <= bus.req_we;
                lat_uns   <= bus.req_unsigned;
                lat_size  <= bus.req_size;
                lat_addr  <= bus.req_addr[DEPTH_LOG2-1:0];
                lat_wdata <= bus.req_wdata;
            end
        end
    end

    // Array write; contents survive reset, an aborted access never reaches completion
    always_ff @(posedge clk) begin
        if (complete_c && lat_we && !err_c) begin
            mem[a[0]] <= lat_wdata[7:0];
            if (lat_size != SZ_BYTE) mem[a[1]] <= lat_wdata[15:8];
            if (lat_size == SZ_WORD) begin
                mem[a[2]] <= lat_wdata[23:16];
                mem[a[3]] <= lat_wdata[31:24];
            end
        end
    end
endmodule
